parking_gate_ctrl: RTL and testbench
====================================

Name: parking_gate_ctrl

Overview:
Parametrised car-park entry controller, the successor to car_parking_system. It checks a PW_WIDTH-bit password before opening the gate and tracks lot occupancy up to CAPACITY. It refuses entry when the lot is full and locks out repeated wrong passwords. It drives the green/red LEDs, a gate-open line and four 7-segment digits (occupancy count plus a two-letter status code).

Parameters:
CAPACITY, 8, number of bays; 1..99
PW_WIDTH, 4, password width in bits
PASSWORD, 4'b1011, expected password (PW_WIDTH bits)
TIMEOUT_CYCLES, 64, cycles to wait for a password before abandoning the entry
MAX_TRIES, 3, wrong attempts allowed before LOCKOUT
LOCK_CYCLES, 16, LOCKOUT duration

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-high reset
sensorEntrance  in  1  car waiting at the entry gate
sensorExit  in  1  car has passed through the entry gate (level)
carLeave  in  1  one-cycle pulse: a car left the lot
passwordEntered  in  PW_WIDTH  password value
passwordValid  in  1  one-cycle strobe; passwordEntered is sampled in this cycle
greenLed  out  1  entry granted
redLed  out  1  entry refused, waiting, or locked
gateOpen  out  1  gate barrier raised
full  out  1  occupancy == CAPACITY
occupancy  out  $clog2(CAPACITY+1)  current car count
display1  out  7  occupancy tens digit
display2  out  7  occupancy units digit
display3  out  7  status letter 1
display4  out  7  status letter 2

Behaviour:
- Segments are active-low, ordered {g,f,e,d,c,b,a}. Blank is 7'h7F.
- All outputs are registered Moore outputs and are valid one cycle after a state or count change.
- Reset values: state=IDLE, occupancy=0, tries=0, timers=0, greenLed=0, redLed=0, gateOpen=0, full=0. display1 and display2 show the digit "0". display3 and display4 are blank.
- Status codes (display3/display4):
  - IDLE: blank/blank
  - WAIT_PASSWORD: "En"
  - WRONG_PASS: "EE"
  - RIGHT_PASS: "GO"
  - STOP: "SP"
  - FULL: "FU"
  - LOCKOUT: "LO"
- IDLE (LEDs off): when sensorEntrance=1, go to FULL if full=1, otherwise go to WAIT_PASSWORD and clear the timer.
- WAIT_PASSWORD and WRONG_PASS:
  - redLed=1 in both states.
  - On passwordValid: a match goes to RIGHT_PASS and clears tries.
  - A mismatch increments tries. If the new tries equals MAX_TRIES, go to LOCKOUT. Otherwise go to WRONG_PASS and restart the timer.
  - If the timer reaches TIMEOUT_CYCLES, or sensorEntrance=0 without a passwordValid in that cycle, go to IDLE. tries is kept.
- RIGHT_PASS (greenLed=1, gateOpen=1):
  - sensorExit=1 with sensorEntrance=0: occupancy++, go to IDLE.
  - sensorExit=1 with sensorEntrance=1 (tailgating car): occupancy++, go to STOP.
- STOP (redLed=1, gateOpen=0): next cycle go to FULL if full, else WAIT_PASSWORD. The following car must enter its own password.
- FULL (redLed=1): go to IDLE when sensorEntrance=0. Go to WAIT_PASSWORD when a departure makes full=0 while sensorEntrance=1.
- LOCKOUT:
  - redLed toggles every cycle, starting at 1.
  - passwordValid is ignored.
  - After LOCK_CYCLES cycles, clear tries and go to IDLE.
- Occupancy arithmetic:
  - Increment and carLeave in the same cycle leave the count unchanged.
  - carLeave at occupancy 0 is ignored.
  - An increment at CAPACITY cannot occur: FULL gating prevents it.
  - carLeave is honoured in every state.
- Rst asserted mid-operation returns all state to reset values at once. Any car count is lost.

Optional Feature:
Macro PARKING_LOCKOUT_EN.
- Defined: the retry counter and LOCKOUT state behave as described above.
- Undefined: there is no tries counter and no LOCKOUT state. Every mismatch goes to WRONG_PASS, and attempts are unlimited. The MAX_TRIES and LOCK_CYCLES parameters are accepted but unused.

Decomposition:
- Package parking_pkg holds:
  - the state enum (IDLE, WAIT_PASSWORD, WRONG_PASS, RIGHT_PASS, STOP, FULL, LOCKOUT)
  - segment constants: digits 0-9, letters E, n, G, O, S, P, F, U, L, and blank
- Sub-module seg7_decoder: 4-bit digit to 7-bit active-low segments. It is instantiated twice, for display1 and display2.
- The binary-to-decimal split (tens/units) stays in the top module.

Test Plan:
1. Reset, then sensorEntrance=1, then passwordValid with 4'b1011, then sensorExit=1 -> states WAIT_PASSWORD -> RIGHT_PASS -> IDLE. greenLed=1 and gateOpen=1 in RIGHT_PASS. occupancy ends at 1, with display2 showing "1".
2. Three wrong passwords (4'b0000) with PARKING_LOCKOUT_EN defined -> "EE" shown after the 1st and 2nd. The 3rd enters LOCKOUT ("LO", redLed toggling). A correct password during LOCKOUT is ignored. Return to IDLE after 16 cycles.
3. Fill the lot to 8, then sensorEntrance=1 -> state FULL, "FU", full=1. A carLeave pulse -> occupancy 7, then WAIT_PASSWORD.
4. In RIGHT_PASS, sensorExit=1 with sensorEntrance=1 -> occupancy++ and STOP ("SP", redLed=1), then WAIT_PASSWORD on the next cycle.
5. sensorEntrance held with no passwordValid for 64 cycles -> IDLE. Separately, carLeave in the same cycle as an increment -> occupancy unchanged; carLeave at 0 -> stays 0.
6. Assert Rst mid-RIGHT_PASS with occupancy 5 -> all outputs return to reset values immediately, occupancy=0, displays show "00" and blank/blank.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and 7-segment glyphs for the car-park entry controller.
// Segments are active-low, bit order {g,f,e,d,c,b,a}.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PASSWORD,
    WRONG_PASS,
    RIGHT_PASS,
    STOP,
    FULL,
    LOCKOUT
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Decimal digit to active-low 7-segment pattern; values above 9 show blank.
module seg7_decoder
  import parking_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (digit)
      4'd0: segments = SEG_0;
      4'd1: segments = SEG_1;
      4'd2: segments = SEG_2;
      4'd3: segments = SEG_3;
      4'd4: segments = SEG_4;
      4'd5: segments = SEG_5;
      4'd6: segments = SEG_6;
      4'd7: segments = SEG_7;
      4'd8: segments = SEG_8;
      4'd9: segments = SEG_9;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Car-park entry controller: password check, occupancy tracking, gate/LED/display drive.
// Optional retry limit with timed lockout is enabled by defining PARKING_LOCKOUT_EN.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY       = 8,
  parameter int PW_WIDTH       = 4,
  parameter logic [PW_WIDTH-1:0] PASSWORD = 4'b1011,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          sensorEntrance,
  input  logic                          sensorExit,
  input  logic                          carLeave,
  input  logic [PW_WIDTH-1:0]           passwordEntered,
  input  logic                          passwordValid,
  output logic                          greenLed,
  output logic                          redLed,
  output logic                          gateOpen,
  output logic                          full,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic [6:0]                    display1,
  output logic [6:0]                    display2,
  output logic [6:0]                    display3,
  output logic [6:0]                    display4
);

  localparam int OCC_W   = $clog2(CAPACITY + 1);
  // One timer serves both the password timeout and the lockout interval.
  localparam int TMR_MAX = (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [OCC_W-1:0]   occ_d;
  logic               inc;
  logic               green_d, red_d, gate_d;
  logic [6:0]         status1_d, status2_d, seg_tens, seg_units;
  logic [3:0]         tens_d, units_d;
  logic               pw_match;
`ifdef PARKING_LOCKOUT_EN
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  logic [TRIES_W-1:0] tries_q, tries_d;
`endif

  assign pw_match = (passwordEntered == PASSWORD);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
`ifdef PARKING_LOCKOUT_EN
    tries_d = tries_q;
`endif
    case (state_q)
      IDLE: begin
        if (sensorEntrance) begin
          if (full) begin
            state_d = FULL;
          end else begin
            state_d = WAIT_PASSWORD;
            timer_d = '0;
          end
        end
      end
      WAIT_PASSWORD, WRONG_PASS: begin
        timer_d = timer_q + 1'b1;
        if (passwordValid) begin
          if (pw_match) begin
            state_d = RIGHT_PASS;
`ifdef PARKING_LOCKOUT_EN
            tries_d = '0;
`endif
          end else begin
            timer_d = '0;
`ifdef PARKING_LOCKOUT_EN
            tries_d = tries_q + 1'b1;
            state_d = (tries_d == TRIES_W'(MAX_TRIES)) ? LOCKOUT : WRONG_PASS;
`else
            state_d = WRONG_PASS;
`endif
          end
        end else if (!sensorEntrance || timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
        end
      end
      RIGHT_PASS: begin
        if (sensorExit) state_d = sensorEntrance ? STOP : IDLE;
      end
      STOP: begin
        state_d = full ? FULL : WAIT_PASSWORD;
        timer_d = '0;
      end
      FULL: begin
        if (!sensorEntrance) begin
          state_d = IDLE;
        end else if (!full) begin
          state_d = WAIT_PASSWORD;
          timer_d = '0;
        end
      end
`ifdef PARKING_LOCKOUT_EN
      LOCKOUT: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TMR_W'(LOCK_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
          tries_d = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous entry and departure cancel out; departures from an empty lot are dropped.
  always_comb begin
    inc   = (state_q == RIGHT_PASS) && sensorExit;
    occ_d = occupancy;
    if (inc && !carLeave)
      occ_d = occupancy + 1'b1;
    else if (!inc && carLeave && occupancy != '0)
      occ_d = occupancy - 1'b1;
    tens_d  = 4'(int'(occ_d) / 10);
    units_d = 4'(int'(occ_d) % 10);
  end

  // Output values are derived from the next state so they register alongside it.
  always_comb begin
    green_d   = 1'b0;
    red_d     = 1'b0;
    gate_d    = 1'b0;
    status1_d = SEG_BLANK;
    status2_d = SEG_BLANK;
    case (state_d)
      WAIT_PASSWORD: begin red_d = 1'b1; status1_d = SEG_E; status2_d = SEG_N; end
      WRONG_PASS:    begin red_d = 1'b1; status1_d = SEG_E; status2_d = SEG_E; end
      RIGHT_PASS:    begin green_d = 1'b1; gate_d = 1'b1; status1_d = SEG_G; status2_d = SEG_O; end
      STOP:          begin red_d = 1'b1; status1_d = SEG_S; status2_d = SEG_P; end
      FULL:          begin red_d = 1'b1; status1_d = SEG_F; status2_d = SEG_U; end
      LOCKOUT: begin
        red_d     = (state_q == LOCKOUT) ? ~redLed : 1'b1;
        status1_d = SEG_L;
        status2_d = SEG_O;
      end
      default: ;
    endcase
  end

  seg7_decoder u_tens  (.digit(tens_d),  .segments(seg_tens));
  seg7_decoder u_units (.digit(units_d), .segments(seg_units));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      greenLed  <= 1'b0;
      redLed    <= 1'b0;
      gateOpen  <= 1'b0;
      display1  <= SEG_0;
      display2  <= SEG_0;
      display3  <= SEG_BLANK;
      display4  <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      occupancy <= occ_d;
      full      <= (occ_d == OCC_W'(CAPACITY));
      greenLed  <= green_d;
      redLed    <= red_d;
      gateOpen  <= gate_d;
      display1  <= seg_tens;
      display2  <= seg_units;
      display3  <= status1_d;
      display4  <= status2_d;
    end
  end

`ifdef PARKING_LOCKOUT_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) tries_q <= '0;
    else     tries_q <= tries_d;
  end
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl; lockout expectations follow PARKING_LOCKOUT_EN.
module tb_parking_gate_ctrl;

  localparam logic [6:0] T_BLANK = 7'h7F;
  localparam logic [6:0] T_D0 = 7'h40;
  localparam logic [6:0] T_D1 = 7'h79;
  localparam logic [6:0] T_D2 = 7'h24;
  localparam logic [6:0] T_D5 = 7'h12;
  localparam logic [6:0] T_D7 = 7'h78;
  localparam logic [6:0] T_D8 = 7'h00;
  localparam logic [6:0] T_E = 7'h06;
  localparam logic [6:0] T_N = 7'h2B;
  localparam logic [6:0] T_G = 7'h42;
  localparam logic [6:0] T_O = 7'h40;
  localparam logic [6:0] T_S = 7'h12;
  localparam logic [6:0] T_P = 7'h0C;
  localparam logic [6:0] T_F = 7'h0E;
  localparam logic [6:0] T_U = 7'h41;
  localparam logic [6:0] T_L = 7'h47;
  localparam logic [3:0] PW_OK  = 4'b1011;
  localparam logic [3:0] PW_BAD = 4'b0000;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       sensorEntrance, sensorExit, carLeave, passwordValid;
  logic [3:0] passwordEntered;
  logic       greenLed, redLed, gateOpen, full;
  logic [3:0] occupancy;
  logic [6:0] display1, display2, display3, display4;

  int checks = 0;
  int errors = 0;

  parking_gate_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .sensorEntrance(sensorEntrance), .sensorExit(sensorExit), .carLeave(carLeave),
    .passwordEntered(passwordEntered), .passwordValid(passwordValid),
    .greenLed(greenLed), .redLed(redLed), .gateOpen(gateOpen), .full(full),
    .occupancy(occupancy),
    .display1(display1), .display2(display2), .display3(display3), .display4(display4)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic applyStimulus(input logic ent, input logic ext, input logic leave,
                               input logic [3:0] pw, input logic valid);
    sensorEntrance  = ent;
    sensorExit      = ext;
    carLeave        = leave;
    passwordEntered = pw;
    passwordValid   = valid;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStatus(input string tag, input logic [6:0] s1, input logic [6:0] s2,
                             input logic g, input logic r, input logic gate);
    checkOutput({tag, "_d3"}, 32'(display3), 32'(s1));
    checkOutput({tag, "_d4"}, 32'(display4), 32'(s2));
    checkOutput({tag, "_green"}, 32'(greenLed), 32'(g));
    checkOutput({tag, "_red"}, 32'(redLed), 32'(r));
    checkOutput({tag, "_gate"}, 32'(gateOpen), 32'(gate));
  endtask

  task automatic checkCount(input string tag, input logic [3:0] occ, input logic f,
                            input logic [6:0] d1, input logic [6:0] d2);
    checkOutput({tag, "_occ"}, 32'(occupancy), 32'(occ));
    checkOutput({tag, "_full"}, 32'(full), 32'(f));
    checkOutput({tag, "_d1"}, 32'(display1), 32'(d1));
    checkOutput({tag, "_d2"}, 32'(display2), 32'(d2));
  endtask

  initial begin
    Rst = 1'b1;
    sensorEntrance = 0; sensorExit = 0; carLeave = 0; passwordValid = 0; passwordEntered = 0;
    repeat (2) @(posedge Clk);
    #1;
    checkStatus("reset", T_BLANK, T_BLANK, 0, 0, 0);
    checkCount("reset", 4'd0, 0, T_D0, T_D0);
    Rst = 1'b0;

    $display("[TB] single entry");
    applyStimulus(1, 0, 0, PW_BAD, 0);
    checkStatus("t1_wait", T_E, T_N, 0, 1, 0);
    applyStimulus(1, 0, 0, PW_OK, 1);
    checkStatus("t1_right", T_G, T_O, 1, 0, 1);
    applyStimulus(0, 1, 0, PW_BAD, 0);
    checkStatus("t1_idle", T_BLANK, T_BLANK, 0, 0, 0);
    checkCount("t1", 4'd1, 0, T_D0, T_D1);

    $display("[TB] wrong passwords");
    applyStimulus(1, 0, 0, PW_BAD, 0);
    applyStimulus(1, 0, 0, PW_BAD, 1);
    checkStatus("t2_wrong1", T_E, T_E, 0, 1, 0);
    applyStimulus(1, 0, 0, PW_BAD, 1);
    checkStatus("t2_wrong2", T_E, T_E, 0, 1, 0);
    applyStimulus(1, 0, 0, PW_BAD, 1);
`ifdef PARKING_LOCKOUT_EN
    checkStatus("t2_lock0", T_L, T_O, 0, 1, 0);
    applyStimulus(1, 0, 0, PW_OK, 1);
    checkStatus("t2_lock1", T_L, T_O, 0, 0, 0);
    applyStimulus(0, 0, 0, PW_BAD, 0);
    checkStatus("t2_lock2", T_L, T_O, 0, 1, 0);
    repeat (13) applyStimulus(0, 0, 0, PW_BAD, 0);
    checkStatus("t2_lock15", T_L, T_O, 0, 0, 0);
    applyStimulus(0, 0, 0, PW_BAD, 0);
    checkStatus("t2_unlock", T_BLANK, T_BLANK, 0, 0, 0);
`else
    checkStatus("t2_wrong3", T_E, T_E, 0, 1, 0);
    applyStimulus(0, 0, 0, PW_BAD, 0);
    checkStatus("t2_leave", T_BLANK, T_BLANK, 0, 0, 0);
`endif
    checkCount("t2", 4'd1, 0, T_D0, T_D1);

    $display("[TB] password timeout");
    applyStimulus(1, 0, 0, PW_BAD, 0);
    repeat (63) applyStimulus(1, 0, 0, PW_BAD, 0);
    checkStatus("t5_wait63", T_E, T_N, 0, 1, 0);
    applyStimulus(1, 0, 0, PW_BAD, 0);
    checkStatus("t5_timeout", T_BLANK, T_BLANK, 0, 0, 0);

    $display("[TB] tailgating");
    applyStimulus(1, 0, 0, PW_BAD, 0);
    applyStimulus(1, 0, 0, PW_OK, 1);
    applyStimulus(1, 1, 0, PW_BAD, 0);
    checkStatus("t4_stop", T_S, T_P, 0, 1, 0);
    checkCount("t4", 4'd2, 0, T_D0, T_D2);
    applyStimulus(1, 0, 0, PW_BAD, 0);
    checkStatus("t4_wait", T_E, T_N, 0, 1, 0);
    applyStimulus(0, 0, 0, PW_BAD, 0);
    checkStatus("t4_idle", T_BLANK, T_BLANK, 0, 0, 0);

    $display("[TB] occupancy arithmetic");
    applyStimulus(1, 0, 0, PW_BAD, 0);
    applyStimulus(1, 0, 0, PW_OK, 1);
    applyStimulus(0, 1, 1, PW_BAD, 0);
    checkCount("t5_inc_leave", 4'd2, 0, T_D0, T_D2);
    applyStimulus(0, 0, 1, PW_BAD, 0);
    checkCount("t5_leave1", 4'd1, 0, T_D0, T_D1);
    applyStimulus(0, 0, 1, PW_BAD, 0);
    checkCount("t5_leave0", 4'd0, 0, T_D0, T_D0);
    applyStimulus(0, 0, 1, PW_BAD, 0);
    checkCount("t5_leave_empty", 4'd0, 0, T_D0, T_D0);

    $display("[TB] full lot");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, PW_BAD, 0);
      applyStimulus(1, 0, 0, PW_OK, 1);
      applyStimulus(0, 1, 0, PW_BAD, 0);
    end
    checkCount("t3_filled", 4'd8, 1, T_D0, T_D8);
    applyStimulus(1, 0, 0, PW_BAD, 0);
    checkStatus("t3_full", T_F, T_U, 0, 1, 0);
    applyStimulus(1, 0, 0, PW_OK, 1);
    checkStatus("t3_full_hold", T_F, T_U, 0, 1, 0);
    applyStimulus(1, 0, 1, PW_BAD, 0);
    checkCount("t3_depart", 4'd7, 0, T_D0, T_D7);
    checkStatus("t3_depart", T_F, T_U, 0, 1, 0);
    applyStimulus(1, 0, 0, PW_BAD, 0);
    checkStatus("t3_reopen", T_E, T_N, 0, 1, 0);
    applyStimulus(0, 0, 0, PW_BAD, 0);

    $display("[TB] reset mid-entry");
    applyStimulus(0, 0, 1, PW_BAD, 0);
    applyStimulus(0, 0, 1, PW_BAD, 0);
    applyStimulus(1, 0, 0, PW_BAD, 0);
    applyStimulus(1, 0, 0, PW_OK, 1);
    checkStatus("t6_right", T_G, T_O, 1, 0, 1);
    checkCount("t6_before", 4'd5, 0, T_D0, T_D5);
    Rst = 1'b1;
    #2;
    checkStatus("t6_reset", T_BLANK, T_BLANK, 0, 0, 0);
    checkCount("t6_reset", 4'd0, 0, T_D0, T_D0);
    #2;
    Rst = 1'b0;
    applyStimulus(0, 0, 0, PW_BAD, 0);
    checkStatus("t6_after", T_BLANK, T_BLANK, 0, 0, 0);
    checkCount("t6_after", 4'd0, 0, T_D0, T_D0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
